// File: rtl/jts18_pri_sweep.sv
// Layer-flag permutation sweeper: routes busin through a run-time permutation that
// walks all NLYR! orderings (Heap's algorithm), stepped by a VBL dwell timer or a button.
module jts18_pri_sweep #(
    parameter int NLYR  = 5,
    parameter int DWELL = 180,
    parameter int IDXW  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            LVBL,
    input  logic [1:0]      buttons,
    input  logic [7:0]      debug_bus,
    input  logic [NLYR-1:0] busin,
    output logic [NLYR-1:0] busout,
    output logic [IDXW-1:0] perm_idx,
    output logic            running,
    output logic            busy,
    output logic            wrap,
    output logic [7:0]      st_show
);

    localparam int PW = $clog2(NLYR);      // holds a layer index 0..NLYR-1
    localparam int IW = $clog2(NLYR + 1);  // Heap index i reaches NLYR

    typedef enum logic [1:0] {IDLE, SEARCH, SWAP, WRAP} state_t;

    state_t        state;
    logic [PW-1:0] perm [NLYR];
    logic [PW-1:0] c    [NLYR];
    logic [IW-1:0] i;
    logic [7:0]    fcnt;
    logic          pending;
    logic [1:0]    buttons_l;
    logic          lvbl_l;

    logic          restart, run_ev, step_ev, tick, dwell_hit, req;
    logic [1:0]    btn_fall;
    logic [PW-1:0] ci, swap_a, perm_i, perm_a;
    logic          unused_dbg;

    assign unused_dbg = ^debug_bus[5:0];

    // Holding both buttons low is a restart and masks the individual button events.
    assign restart   = ~buttons[0] & ~buttons[1];
    assign btn_fall  = buttons_l & ~buttons;
    assign run_ev    = btn_fall[0] & ~restart;
    assign step_ev   = btn_fall[1] & ~restart;
    assign tick      = LVBL & ~lvbl_l & running & ~debug_bus[6];
    assign dwell_hit = tick && (fcnt == 8'(DWELL - 1));
    assign req       = step_ev | dwell_hit;

    // Operand selection for the Heap step: c[i], perm[i], and the swap partner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ci     = '0;
        perm_i = '0;
        perm_a = '0;
        for (int k = 0; k < NLYR; k++) begin
            if (i == IW'(k)) begin
                ci     = c[k];
                perm_i = perm[k];
            end
        end
        swap_a = i[0] ? ci : '0;
        for (int k = 0; k < NLYR; k++) begin
            if (swap_a == PW'(k)) perm_a = perm[k];
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every read sees the
    // pre-edge value; the small perm/c arrays are flops and are reset to identity/zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i         <= IW'(1);
            fcnt      <= '0;
            pending   <= 1'b0;
            perm_idx  <= '0;
            running   <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            buttons_l <= 2'b11;
            lvbl_l    <= 1'b0;
            for (int k = 0; k < NLYR; k++) begin
                perm[k] <= PW'(k);
                c[k]    <= '0;
            end
        end else begin
            buttons_l <= buttons;
            lvbl_l    <= LVBL;
            wrap      <= 1'b0;
            if (restart) begin
                state    <= IDLE;
                i        <= IW'(1);
                fcnt     <= '0;
                pending  <= 1'b0;
                perm_idx <= '0;
                running  <= 1'b0;
                busy     <= 1'b0;
                for (int k = 0; k < NLYR; k++) begin
                    perm[k] <= PW'(k);
                    c[k]    <= '0;
                end
            end else begin
                if (run_ev) running <= ~running;
                if (tick)   fcnt    <= dwell_hit ? 8'd0 : fcnt + 8'd1;
                // A request arriving mid-step is parked once; any further ones are dropped.
                if (state != IDLE && req) pending <= 1'b1;

                case (state)
                    IDLE: begin
                        if (req || pending) begin
                            state   <= SEARCH;
                            busy    <= 1'b1;
                            pending <= 1'b0;
                        end
                    end
                    SEARCH: begin
                        if (i == IW'(NLYR)) begin
                            state <= WRAP;
                            wrap  <= 1'b1;
                        end else if (IW'(ci) < i) begin
                            state <= SWAP;
                        end else begin
                            for (int k = 0; k < NLYR; k++) begin
                                if (i == IW'(k)) c[k] <= '0;
                            end
                            i <= i + IW'(1);
                        end
                    end
                    SWAP: begin
                        for (int k = 0; k < NLYR; k++) begin
                            if (swap_a == PW'(k))  perm[k] <= perm_i;
                            else if (i == IW'(k))  perm[k] <= perm_a;
                            if (i == IW'(k))       c[k]    <= ci + PW'(1);
                        end
                        i        <= IW'(1);
                        perm_idx <= perm_idx + IDXW'(1);
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    WRAP: begin
                        for (int k = 0; k < NLYR; k++) begin
                            perm[k] <= PW'(k);
                            c[k]    <= '0;
                        end
                        i        <= IW'(1);
                        perm_idx <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busout <= '0;
        end else begin
            for (int k = 0; k < NLYR; k++) busout[k] <= busin[perm[k]];
        end
    end

    assign st_show = debug_bus[7] ? 8'(perm_idx) : {running, busy, pending, fcnt[4:0]};

endmodule
